// File: rtl/dp_acc_pkg.sv
// dp_acc_pkg: default widths and FSM state type
// shared by the dp_acc_seq accumulator and its align/add datapath.
package dp_acc_pkg;

  localparam int MANT_W_DEF = 52;
  localparam int EXP_W_DEF  = 8;
  localparam int LEN_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/dp_acc_seq_align_add.sv
// dp_align_add: exponent-align two signed mantissas, add, flag overflow.
// Build option DP_ACC_SAT_EN saturates the sum instead of wrapping.
module dp_align_add #(
  parameter int MANT_W = 52,
  parameter int EXP_W  = 8
) (
  input  logic [MANT_W-1:0] acc_i,
  input  logic [EXP_W-1:0]  acc_exp_i,
  input  logic [MANT_W-1:0] mant_i,
  input  logic [EXP_W-1:0]  exp_i,
  output logic [MANT_W-1:0] sum_o,
  output logic [EXP_W-1:0]  exp_o,
  output logic              ovf_o
);

  logic              acc_big;
  logic [EXP_W-1:0]  diff;
  int unsigned       sh;
  logic [MANT_W-1:0] acc_sh;
  logic [MANT_W-1:0] mant_sh;
  logic [MANT_W-1:0] op_a;
  logic [MANT_W-1:0] op_b;
  logic [MANT_W-1:0] sum_raw;

  always_comb begin
    acc_big = (acc_exp_i >= exp_i);
    diff    = acc_big ? (acc_exp_i - exp_i)
                      : (exp_i - acc_exp_i);
    // shifting by MANT_W-1 already yields pure sign fill
    sh = (32'(diff) >= 32'(MANT_W - 1))
       ? 32'(MANT_W - 1) : 32'(diff);
    acc_sh  = $signed(acc_i) >>> sh;
    mant_sh = $signed(mant_i) >>> sh;
    op_a    = acc_big ? acc_i : acc_sh;
    op_b    = acc_big ? mant_sh : mant_i;
    sum_raw = op_a + op_b;
    ovf_o   = (op_a[MANT_W-1] == op_b[MANT_W-1])
           && (sum_raw[MANT_W-1] != op_a[MANT_W-1]);
    exp_o   = acc_big ? acc_exp_i : exp_i;
`ifdef DP_ACC_SAT_EN
    if (ovf_o)
      sum_o = op_a[MANT_W-1] ? {1'b1, {(MANT_W-1){1'b0}}}
                             : {1'b0, {(MANT_W-1){1'b1}}};
    else
      sum_o = sum_raw;
`else
    sum_o = sum_raw;
`endif
  end

endmodule

// File: rtl/dp_acc_seq.sv
// dp_acc_seq: sequential block-floating-point accumulator (IDLE/ACCUM/DONE).
// Saturating adds are selected at build time with DP_ACC_SAT_EN.
module dp_acc_seq
  import dp_acc_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  job_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant_pos,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic              ovf,
  output logic              busy
);

  state_e            state_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [MANT_W-1:0] acc_q;
  logic [EXP_W-1:0]  acc_exp_q;
  logic              ovf_q;
  logic              first_q;
  logic [MANT_W-1:0] mag_q;
  logic              sign_q;
  logic [EXP_W-1:0]  oexp_q;

  logic [MANT_W-1:0] sum;
  logic [EXP_W-1:0]  sum_exp;
  logic              add_ovf;
  logic [MANT_W-1:0] acc_d;
  logic [EXP_W-1:0]  exp_d;
  logic              ovf_d;
  logic [MANT_W-1:0] mag_d;

  dp_align_add #(
    .MANT_W (MANT_W),
    .EXP_W  (EXP_W)
  ) u_align_add (
    .acc_i     (acc_q),
    .acc_exp_i (acc_exp_q),
    .mant_i    (in_mant),
    .exp_i     (in_exp),
    .sum_o     (sum),
    .exp_o     (sum_exp),
    .ovf_o     (add_ovf)
  );

  always_comb begin
    acc_d = first_q ? in_mant : sum;
    exp_d = first_q ? in_exp : sum_exp;
    ovf_d = ovf_q | (~first_q & add_ovf);
    mag_d = acc_d[MANT_W-1] ? (~acc_d + MANT_W'(1)) : acc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      acc_exp_q <= '0;
      ovf_q     <= 1'b0;
      first_q   <= 1'b0;
      mag_q     <= '0;
      sign_q    <= 1'b0;
      oexp_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          cnt_q     <= job_len;
          acc_q     <= '0;
          acc_exp_q <= '0;
          ovf_q     <= 1'b0;
          first_q   <= 1'b1;
          if (job_len == '0) begin
            state_q <= DONE;
            mag_q   <= '0;
            sign_q  <= 1'b0;
            oexp_q  <= '0;
          end else begin
            state_q <= ACCUM;
          end
        end
        ACCUM: if (in_valid) begin
          acc_q     <= acc_d;
          acc_exp_q <= exp_d;
          ovf_q     <= ovf_d;
          first_q   <= 1'b0;
          cnt_q     <= cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_q <= DONE;
            mag_q   <= mag_d;
            sign_q  <= acc_d[MANT_W-1];
            oexp_q  <= exp_d;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready     = (state_q == ACCUM);
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign out_mant_pos = mag_q;
  assign out_sign     = sign_q;
  assign out_exp      = oexp_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_dp_acc_seq.sv
// tb_dp_acc_seq: directed self-checking bench for dp_acc_seq.
// Expected values are hand-computed from the accumulator definition.
module tb_dp_acc_seq;

  localparam int MW = 52;
  localparam int EW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] job_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [EW-1:0] in_exp = '0;
  logic [MW-1:0] in_mant = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [MW-1:0] out_mant_pos;
  logic          out_sign;
  logic [EW-1:0] out_exp;
  logic          ovf;
  logic          busy;

  int tests = 0;
  int fails = 0;

  dp_acc_seq #(.MANT_W(MW), .EXP_W(EW), .LEN_W(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .job_len      (job_len),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_exp       (in_exp),
    .in_mant      (in_mant),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_mant_pos (out_mant_pos),
    .out_sign     (out_sign),
    .out_exp      (out_exp),
    .ovf          (ovf),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic begin_job(input logic [LW-1:0] len);
    start   = 1'b1;
    job_len = len;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic send(input logic [EW-1:0] e, input logic [MW-1:0] m);
    int n = 0;
    in_valid = 1'b1;
    in_exp   = e;
    in_mant  = m;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 64'(n < 20), 64'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic result(input string tag, input logic [MW-1:0] mag,
                        input logic sgn, input logic [EW-1:0] e,
                        input logic o);
    chk({tag, "_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_mag"}, 64'(out_mant_pos), 64'(mag));
    chk({tag, "_sign"}, 64'(out_sign), 64'(sgn));
    chk({tag, "_exp"}, 64'(out_exp), 64'(e));
    chk({tag, "_ovf"}, 64'(ovf), 64'(o));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_idle", 64'({busy, out_valid}), 64'(0));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_outs", 64'({in_ready, out_valid, ovf}), 64'(0));
    chk("rst_mag", 64'(out_mant_pos), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    begin_job(4'd2);
    chk("accum_rdy", 64'({busy, in_ready, out_valid}), 64'(3'b110));
    send(8'd10, MW'(32'h100));
    send(8'd8, MW'(32'h40));
    result("align", MW'(32'h110), 1'b0, 8'd10, 1'b0);
    drain();

    begin_job(4'd2);
    send(8'd5, MW'(-300));
    send(8'd5, MW'(100));
    result("neg", MW'(200), 1'b1, 8'd5, 1'b0);
    drain();

    begin_job(4'd2);
    send(8'd0, 52'h7_FFFF_FFFF_FFFF);
    send(8'd0, MW'(1));
`ifdef DP_ACC_SAT_EN
    result("ovf", 52'h7_FFFF_FFFF_FFFF, 1'b0, 8'd0, 1'b1);
`else
    result("ovf", 52'h8_0000_0000_0000, 1'b1, 8'd0, 1'b1);
`endif
    drain();
    chk("ovf_clr_start", 64'(ovf), 64'(1));
    begin_job(4'd1);
    chk("ovf_cleared", 64'(ovf), 64'(0));
    send(8'd3, MW'(4));
    result("one", MW'(4), 1'b0, 8'd3, 1'b0);
    drain();

    begin_job(4'd2);
    send(8'd0, MW'(-5));
    send(8'd60, MW'(3));
    result("signfill", MW'(2), 1'b0, 8'd60, 1'b0);
    drain();

    begin_job(4'd2);
    send(8'd3, MW'(7));
    send(8'd1, MW'(8));
    for (int i = 0; i < 3; i++) begin
      start   = (i == 1);
      job_len = 4'd5;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      result("hold", MW'(9), 1'b0, 8'd3, 1'b0);
      chk("hold_inrdy", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    start     = 1'b1;
    job_len   = 4'd1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    chk("hs_start_ign", 64'({busy, out_valid}), 64'(0));
    @(negedge clk);
    chk("still_idle", 64'(busy), 64'(0));

    begin_job(4'd3);
    send(8'd2, MW'(11));
    chk("mid_busy", 64'(busy), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'({busy, in_ready, out_valid}), 64'(0));
    chk("arst_mag", 64'(out_mant_pos), 64'(0));
    chk("arst_misc", 64'({out_sign, out_exp, ovf}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    begin_job(4'd0);
    result("zero", MW'(0), 1'b0, 8'd0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dp_acc_seq.md
DP_ACC_SEQ -- requirements
Module: dp_acc_seq

Interface
REQ-001 SHALL have parameter MANT_W, default 52, signed partial-sum mantissa width.
REQ-002 SHALL have parameter EXP_W, default 8, unsigned exponent width.
REQ-003 SHALL have parameter LEN_W, default 4, term-count width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-006 SHALL have port start  input  1  request to begin a new accumulation job.
REQ-007 SHALL have port job_len  input  LEN_W  number of terms in the job, sampled with start.
REQ-008 SHALL have port in_valid  input  1  term valid.
REQ-009 SHALL have port in_ready  output  1  term accepted when in_valid and in_ready are both high.
REQ-010 SHALL have port in_exp  input  EXP_W  term exponent.
REQ-011 SHALL have port in_mant  input  MANT_W  term mantissa, two's complement.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  result consumed when out_valid and out_ready are both high.
REQ-014 SHALL have port out_mant_pos  output  MANT_W  magnitude of the accumulated sum.
REQ-015 SHALL have port out_sign  output  1  sign of the accumulated sum (bit MANT_W-1).
REQ-016 SHALL have port out_exp  output  EXP_W  exponent of the result.
REQ-017 SHALL have port ovf  output  1  sticky signed-overflow flag for the current job.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-020 In IDLE, start=1 SHALL load the counter from job_len, clear acc, acc_exp and ovf, and go to ACCUM; if job_len=0, it SHALL go directly to DONE with a zero result.
REQ-021 start SHALL be ignored outside IDLE.
REQ-022 in_ready SHALL be 1 only in ACCUM; out_valid SHALL be 1 only in DONE.
REQ-023 First accepted term SHALL load acc=in_mant and acc_exp=in_exp unchanged.
REQ-024 Each later term SHALL be aligned: the larger exponent becomes acc_exp, and the operand with the smaller exponent is arithmetic-right-shifted by the exponent difference. A difference of MANT_W-1 or more SHALL give pure sign fill. Equal exponents SHALL use no shift.
REQ-025 acc SHALL become the MANT_W-bit two's-complement sum of the aligned operands, wrapping on overflow.
REQ-026 ovf SHALL set when both operands have equal sign and the sum sign differs; it SHALL then stay set until the next start.
REQ-027 Each accepted term SHALL decrement the counter; accepting the last term SHALL move to DONE, so out_valid rises the cycle after the last handshake.
REQ-028 In DONE, out_sign SHALL be acc[MANT_W-1], out_exp SHALL be acc_exp, and out_mant_pos SHALL be ~acc+1 if negative, else acc. The most-negative value SHALL yield 1 followed by zeros.
REQ-029 Outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-030 The out handshake SHALL return the FSM to IDLE; a start in that same cycle SHALL be ignored.

Reset
REQ-031 rst SHALL force IDLE and clear acc, acc_exp, counter, ovf, out_* and busy to 0 immediately, including mid-job; terms in flight SHALL be discarded.

Configuration
REQ-032 With DP_ACC_SAT_EN defined, overflow SHALL saturate acc to 0x7FF..F for a positive operand pair or 0x800..0 for a negative pair, and ovf SHALL still set.
REQ-033 Without DP_ACC_SAT_EN, acc SHALL wrap per REQ-025.

Structure
REQ-034 Package dp_acc_pkg SHALL hold MANT_W, EXP_W, LEN_W defaults and the FSM state enum.
REQ-035 Sub-module dp_align_add (combinational align, add and overflow detect) SHALL be instantiated once.

Verification
REQ-036 Test alignment: job_len=2, terms (exp 10, 0x100) then (exp 8, 0x40) -> out_mant_pos=0x110, out_sign=0, out_exp=10, ovf=0.
REQ-037 Test negative result: job_len=2, terms (5, -300) then (5, 100) -> out_mant_pos=200, out_sign=1, out_exp=5.
REQ-038 Test overflow: job_len=2, terms (0, 0x7_FFFF_FFFF_FFFF) then (0, 1) -> acc 0x8_0000_0000_0000 with ovf=1, or 0x7_FFFF_FFFF_FFFF with ovf=1 under DP_ACC_SAT_EN.
REQ-039 Test back-pressure: hold out_ready=0 for 3 cycles in DONE and pulse start -> outputs stable, in_ready=0, start ignored.
REQ-040 Test reset and short job: assert rst after 1 of 3 terms -> busy=0 and outputs 0 asynchronously; then job_len=0 -> zero result the next cycle.
